// File: rtl/seq_mul32u_pkg.sv
// MULDIV shared definitions: FSM state encoding (also used by the divider) and default operand width.
package seq_mul32u_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    PREP   = 2'd0,
    LOOP   = 2'd1,
    FINISH = 2'd2,
    FREE   = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/seq_mul32u.sv
// Radix-2 shift-add unsigned multiplier, full 2*WIDTH product; busy 1+WIDTH cycles after start, start ignored while busy.
// Zero operands bypass the loop combinationally; MUL_EARLYEXIT_EN stops the loop once the multiplier is exhausted.
module seq_mul32u
  import seq_mul32u_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic               clk,
  input  logic               rstLow,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               start_in,
  output logic [2*WIDTH-1:0] p_out,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_e        state;
  logic [2*WIDTH-1:0]   reg_acc;
  logic [2*WIDTH-1:0]   reg_mc;
  logic [WIDTH-1:0]     reg_mp;
  logic [CW-1:0]        count;

  logic zero;
  logic go;
  logic last;

  assign zero  = (~|a_in) | (~|b_in);
  assign go    = start_in & ~zero;
  assign p_out = zero ? '0 : reg_acc;

  always_comb begin
    last = (count == CW'(WIDTH - 1));
`ifdef MUL_EARLYEXIT_EN
    // Nothing left to add once the bits still to be shifted in are all zero.
    last = last | (reg_mp[WIDTH-1:1] == '0);
`endif
  end

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      state   <= FINISH;
      busy    <= 1'b0;
      reg_acc <= '0;
      reg_mc  <= '0;
      reg_mp  <= '0;
      count   <= '0;
    end else begin
      case (state)
        PREP: begin
          reg_acc <= '0;
          reg_mc  <= {{WIDTH{1'b0}}, a_in};
          reg_mp  <= b_in;
          count   <= '0;
          state   <= LOOP;
        end
        LOOP: begin
          if (reg_mp[0]) reg_acc <= reg_acc + reg_mc;
          reg_mc <= reg_mc << 1;
          reg_mp <= reg_mp >> 1;
          count  <= count + CW'(1);
          if (last) begin
            state <= FINISH;
            busy  <= 1'b0;
          end
        end
        default: begin
          // FINISH and the unused FREE encoding both idle here.
          if (go) begin
            state <= PREP;
            busy  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
